id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_stage : register file with write-back bypass, load-use detection, ID/EX |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module id_stage #(
  parameter int         XLEN    = 32,
  parameter int         NREG    = 32,
  parameter logic [5:0] LOAD_OP = 6'b100011,
  localparam int        AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     NPC_if,
  input  logic [31:0]     IR_if,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            stall,
  output logic            valid_ex,
  output logic [XLEN-1:0] A_ex,
  output logic [XLEN-1:0] B_ex,
  output logic [XLEN-1:0] Imm_ex,
  output logic [31:0]     NPC_ex,
  output logic [31:0]     IR_ex,
  output logic [AW-1:0]   rd_ex,
  output logic [5:0]      op_ex
);

  logic [XLEN-1:0] regs [NREG];

  logic [5:0]      op;
  logic [AW-1:0]   rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            hazard;
  logic            load_bubble;
  logic            load_new;

  assign op  = IR_if[31:26];
  assign rd  = IR_if[21 +: AW];
  assign rs1 = IR_if[16 +: AW];
  assign rs2 = IR_if[11 +: AW];
  assign imm = {{(XLEN-16){IR_if[15]}}, IR_if[15:0]};

  // Same-cycle write-back wins over the stored value; r0 always reads zero.
  always_comb begin
    opa = regs[rs1];
    if (wb_en && (wb_addr == rs1)) opa = wb_data;
    if (rs1 == '0)                 opa = '0;
    opb = regs[rs2];
    if (wb_en && (wb_addr == rs2)) opb = wb_data;
    if (rs2 == '0)                 opb = '0;
  end

  assign hazard = valid_ex && (op_ex == LOAD_OP) && (rd_ex != '0) && if_valid &&
                  ((rd_ex == rs1) || (rd_ex == rs2));

  assign stall       = !flush && (ex_hold || hazard);
  assign load_bubble = flush || (!ex_hold && (hazard || !if_valid));
  assign load_new    = !flush && !ex_hold && !hazard && if_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_ex <= 1'b0;
      A_ex     <= '0;
      B_ex     <= '0;
      Imm_ex   <= '0;
      NPC_ex   <= '0;
      IR_ex    <= '0;
      rd_ex    <= '0;
      op_ex    <= '0;
    end else if (load_bubble) begin
      valid_ex <= 1'b0;
      A_ex     <= '0;
      B_ex     <= '0;
      Imm_ex   <= '0;
      NPC_ex   <= '0;
      IR_ex    <= '0;
      rd_ex    <= '0;
      op_ex    <= '0;
    end else if (load_new) begin
      valid_ex <= 1'b1;
      A_ex     <= opa;
      B_ex     <= opb;
      Imm_ex   <= imm;
      NPC_ex   <= NPC_if;
      IR_ex    <= IR_if;
      rd_ex    <= rd;
      op_ex    <= op;
    end
  end

endmodule
`default_nettype wire
